// File: rtl/mult_pkg.sv
// Shared types and codes for the 8x8 nibble-serial multiply-accumulate controller.
// The error-detect option is enabled elsewhere by defining MULT_ACCUM_ERR_EN.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] SHIFT_0 = 2'b00;
   localparam logic [1:0] SHIFT_4 = 2'b01;
   localparam logic [1:0] SHIFT_8 = 2'b10;

   // sel bit1 picks the A nibble, bit0 picks the B nibble (0 = low nibble)
   localparam logic [1:0] SEL_ALO_BLO = 2'b00;
   localparam logic [1:0] SEL_ALO_BHI = 2'b01;
   localparam logic [1:0] SEL_AHI_BLO = 2'b10;
   localparam logic [1:0] SEL_AHI_BHI = 2'b11;

   function automatic logic [1:0] selForCnt(input logic [1:0] cnt);
      logic [1:0] code;
      code = SEL_ALO_BLO;
      case (cnt)
         2'd1:    code = SEL_ALO_BHI;
         2'd2:    code = SEL_AHI_BLO;
         2'd3:    code = SEL_AHI_BHI;
         default: code = SEL_ALO_BLO;
      endcase
      return code;
   endfunction

   // Partial-product weight is the sum of the chosen nibble weights
   function automatic logic [1:0] shiftForCnt(input logic [1:0] cnt);
      logic [1:0] code;
      code = SHIFT_0;
      case (cnt)
         2'd1, 2'd2: code = SHIFT_4;
         2'd3:       code = SHIFT_8;
         default:    code = SHIFT_0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/mult_accum_ctrl_if.sv
// Bus between the multiply-accumulate controller and its shifter/consumer side.
// The controller uses the slave modport; the environment drives the master side.
interface mult_accum_ctrl_if #(parameter int ACC_W = 16);

   logic             start;
   logic [ACC_W-1:0] shift_out;
   logic [1:0]       sel;
   logic [1:0]       shift_cntrl;
   logic [ACC_W-1:0] product;
   logic             done_flag;
   logic             busy;
   logic             err;

   modport master (
      output start, shift_out,
      input  sel, shift_cntrl, product, done_flag, busy, err
   );

   modport slave (
      input  start, shift_out,
      output sel, shift_cntrl, product, done_flag, busy, err
   );

endinterface

// File: rtl/mult_cycle_cnt.sv
// Two-bit step counter for the multiply sequence; clear has priority over enable.
module mult_cycle_cnt (
   input  logic       clk,
   input  logic       reset_a,
   input  logic       i_clear,
   input  logic       i_enable,
   output logic [1:0] o_cnt
);

   logic [1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         r_cnt <= 2'd0;
      end else if (i_clear) begin
         r_cnt <= 2'd0;
      end else if (i_enable) begin
         r_cnt <= r_cnt + 2'd1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/mult_accum_ctrl.sv
// Sequences four nibble partial products through the shifter and accumulates them.
// Define MULT_ACCUM_ERR_EN to flag start requests that arrive while a multiply runs.
module mult_accum_ctrl
   import mult_pkg::*;
#(
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             reset_a,
   mult_accum_ctrl_if.slave bus
);

   state_t           r_state;
   state_t           w_nextState;
   logic [1:0]       w_cnt;
   logic             w_cntClear;
   logic             w_cntEnable;
   logic [ACC_W-1:0] r_product;
   logic [ACC_W-1:0] w_nextProduct;
   logic             r_done;
   logic             w_nextDone;
   logic             r_busy;
   logic             w_nextBusy;
   logic [1:0]       w_sel;
   logic [1:0]       w_shift;

   mult_cycle_cnt u_cnt (
      .clk      (clk),
      .reset_a  (reset_a),
      .i_clear  (w_cntClear),
      .i_enable (w_cntEnable),
      .o_cnt    (w_cnt)
   );

   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         r_state   <= IDLE;
         r_product <= '0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_product <= w_nextProduct;
         r_done    <= w_nextDone;
         r_busy    <= w_nextBusy;
      end
   end

   // Counter is held at zero outside CALC, so every run begins at step 0
   always_comb begin
      w_nextState   = r_state;
      w_nextProduct = r_product;
      w_nextDone    = r_done;
      w_nextBusy    = r_busy;
      w_cntClear    = 1'b1;
      w_cntEnable   = 1'b0;
      w_sel         = SEL_ALO_BLO;
      w_shift       = SHIFT_0;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_nextState = CALC;
               w_nextDone  = 1'b0;
               w_nextBusy  = 1'b1;
            end
         end
         CALC: begin
            w_cntClear  = 1'b0;
            w_cntEnable = 1'b1;
            w_sel       = selForCnt(w_cnt);
            w_shift     = shiftForCnt(w_cnt);
            if (w_cnt == 2'd0) begin
               w_nextProduct = bus.shift_out;
            end else begin
               w_nextProduct = r_product + bus.shift_out;
            end
            if (w_cnt == 2'd3) begin
               w_nextState = DONE;
               w_nextDone  = 1'b1;
               w_nextBusy  = 1'b0;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextBusy  = 1'b0;
            w_nextDone  = 1'b0;
         end
      endcase
   end

   assign bus.sel         = w_sel;
   assign bus.shift_cntrl = w_shift;
   assign bus.product     = r_product;
   assign bus.done_flag   = r_done;
   assign bus.busy        = r_busy;

`ifdef MULT_ACCUM_ERR_EN
   logic r_err;

   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         r_err <= 1'b0;
      end else if ((r_state == CALC) && bus.start) begin
         r_err <= 1'b1;
      end
   end

   assign bus.err = r_err;
`else
   assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_accum_ctrl.sv
// Self-checking bench for mult_accum_ctrl: models the nibble multiplier/shifter upstream
// and compares the DUT every cycle against an operation-level reference model.
module tb_mult_accum_ctrl;

`ifdef MULT_ACCUM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_a = 1'b0;
   logic [7:0] opA = 8'h00;
   logic [7:0] opB = 8'h00;
   int         checks = 0;
   int         failures = 0;

   mult_accum_ctrl_if #(.ACC_W(16)) bus ();

   mult_accum_ctrl #(.ACC_W(16)) dut (
      .clk     (clk),
      .reset_a (reset_a),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Upstream chain: 4x4 product of the selected nibbles, shifted by the requested weight
   logic [3:0]  upA;
   logic [3:0]  upB;
   logic [15:0] upProd;
   assign upA    = bus.sel[1] ? opA[7:4] : opA[3:0];
   assign upB    = bus.sel[0] ? opB[7:4] : opB[3:0];
   assign upProd = 16'(upA) * 16'(upB);

   always_comb begin
      case (bus.shift_cntrl)
         2'b01:   bus.shift_out = upProd << 4;
         2'b10:   bus.shift_out = upProd << 8;
         default: bus.shift_out = upProd;
      endcase
   end

   // Reference model: an accepted start opens a 4-cycle window, then the product is A*B
   int          mPhase = -1;
   logic        mDone = 1'b0;
   logic        mErr = 1'b0;
   logic [15:0] mProduct = 16'h0000;
   logic [7:0]  mA = 8'h00;
   logic [7:0]  mB = 8'h00;

   always @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         mPhase   <= -1;
         mDone    <= 1'b0;
         mErr     <= 1'b0;
         mProduct <= 16'h0000;
      end else if (mPhase >= 0) begin
         if (bus.start && ERR_EN) mErr <= 1'b1;
         if (mPhase == 3) begin
            mPhase   <= -1;
            mDone    <= 1'b1;
            mProduct <= 16'(mA) * 16'(mB);
         end else begin
            mPhase <= mPhase + 1;
         end
      end else if (bus.start) begin
         mPhase <= 0;
         mDone  <= 1'b0;
         mA     <= opA;
         mB     <= opB;
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Step k of a run uses nibble pair k; the shift code is the sum of the two nibble weights
   logic [1:0] eSel;
   logic [1:0] eShift;
   always @(negedge clk) begin
      if (mPhase >= 0) begin
         eSel = 2'(mPhase);
      end else begin
         eSel = 2'b00;
      end
      eShift = 2'(eSel[1]) + 2'(eSel[0]);
      checkOutput("cyc_sel", 16'(bus.sel), 16'(eSel));
      checkOutput("cyc_shift", 16'(bus.shift_cntrl), 16'(eShift));
      checkOutput("cyc_busy", 16'(bus.busy), 16'(mPhase >= 0));
      checkOutput("cyc_done", 16'(bus.done_flag), 16'(mDone));
      checkOutput("cyc_err", 16'(bus.err), 16'(mErr));
      if (mPhase < 0) checkOutput("cyc_product", bus.product, mProduct);
   end

   // Pulses start for one edge; returns just after the edge that sampled it
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
      @(posedge clk);
      #1;
      opA       = a;
      opB       = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic expectRun(input string tag, input logic [15:0] expProd);
      checkOutput({tag, "_busy0"}, 16'(bus.busy), 16'd1);
      checkOutput({tag, "_done0"}, 16'(bus.done_flag), 16'd0);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         if (k < 4) begin
            checkOutput({tag, "_busyMid"}, 16'(bus.busy), 16'd1);
            checkOutput({tag, "_doneEarly"}, 16'(bus.done_flag), 16'd0);
         end
      end
      checkOutput({tag, "_done"}, 16'(bus.done_flag), 16'd1);
      checkOutput({tag, "_busyEnd"}, 16'(bus.busy), 16'd0);
      checkOutput({tag, "_product"}, bus.product, expProd);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_product"}, bus.product, 16'h0000);
      checkOutput({tag, "_busy"}, 16'(bus.busy), 16'd0);
      checkOutput({tag, "_done"}, 16'(bus.done_flag), 16'd0);
      checkOutput({tag, "_sel"}, 16'(bus.sel), 16'd0);
      checkOutput({tag, "_shift"}, 16'(bus.shift_cntrl), 16'd0);
      checkOutput({tag, "_err"}, 16'(bus.err), 16'd0);
   endtask

   initial begin
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkResetValues("rst");
      reset_a = 1'b1;

      applyStimulus(8'h12, 8'h34);
      expectRun("s1", 16'h03A8);

      applyStimulus(8'hFF, 8'hFF);
      expectRun("s2a", 16'hFE01);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("s2_hold", bus.product, 16'hFE01);
      applyStimulus(8'h00, 8'hAB);
      expectRun("s2b", 16'h0000);

      applyStimulus(8'h5A, 8'hC3);
      repeat (2) @(posedge clk);
      #1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checkOutput("s3_doneEarly", 16'(bus.done_flag), 16'd0);
      checkOutput("s3_busy", 16'(bus.busy), 16'd1);
      @(posedge clk);
      #1;
      checkOutput("s3_done", 16'(bus.done_flag), 16'd1);
      checkOutput("s3_product", bus.product, 16'h448E);
      checkOutput("s3_err", 16'(bus.err), 16'(ERR_EN));

      applyStimulus(8'h77, 8'h99);
      @(posedge clk);
      #3;
      reset_a = 1'b0;
      #1;
      checkResetValues("s4rst");
      @(posedge clk);
      #1;
      reset_a = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("s4_idleBusy", 16'(bus.busy), 16'd0);
      applyStimulus(8'h9C, 8'h2B);
      expectRun("s4", 16'h1A34);

      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (mPhase < 0 && $urandom_range(0, 2) == 0) begin
            opA = 8'($urandom);
            opB = 8'($urandom);
         end
         bus.start = ($urandom_range(0, 3) == 0);
      end
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_accum_ctrl.md
MULT_ACCUM_CTRL -- requirements
Module: mult_accum_ctrl

Interface
REQ-001 SHALL have parameter ACC_W, default 16, accumulator/product width; only 16 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset_a  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new 8x8 multiply; sampled only in IDLE or DONE.
REQ-005 SHALL have port shift_out  input  16  shifted partial product from the shifter stage.
REQ-006 SHALL have port sel  output  2  nibble select: bit1 picks the A nibble, bit0 picks the B nibble (0=lo, 1=hi).
REQ-007 SHALL have port shift_cntrl  output  2  shifter code: 00=no shift, 01=shift 4, 10=shift 8.
REQ-008 SHALL have port product  output  16  accumulated result, registered.
REQ-009 SHALL have ports done_flag and busy  output  1 each, both registered.
REQ-010 SHALL have port err  output  1  sticky protocol error (see REQ-027).

Function
REQ-011 SHALL implement the FSM states IDLE, CALC and DONE, plus a 2-bit cycle counter cnt.
REQ-012 SHALL move IDLE->CALC with cnt=0 on an edge where start=1; otherwise it SHALL stay in IDLE.
REQ-013 SHALL drive sel and shift_cntrl combinationally from the state and cnt, as follows:
- cnt=0: sel=00, shift_cntrl=00
- cnt=1: sel=01, shift_cntrl=01
- cnt=2: sel=10, shift_cntrl=01
- cnt=3: sel=11, shift_cntrl=10
REQ-014 SHALL drive sel=00 and shift_cntrl=00 in IDLE and DONE.
REQ-015 SHALL never emit shift_cntrl=11.
REQ-016 SHALL, in CALC with cnt=0, load product<=shift_out, so that no separate clear cycle is needed.
REQ-017 SHALL, in CALC with cnt=1..3, update product<=product+shift_out, modulo 2^16 (no carry-out is kept).
REQ-018 SHALL increment cnt each CALC cycle and SHALL move CALC->DONE on the edge where cnt=3.
REQ-019 SHALL, on that edge, set done_flag=1 and busy=0, with product final.
REQ-020 SHALL assert busy=1 throughout CALC and hold busy=0 otherwise.
REQ-021 SHALL have a latency of 4 cycles: start sampled at edge N gives done_flag=1 after edge N+4.
REQ-022 SHALL, in DONE, hold product and done_flag until start=1.
REQ-023 SHALL, when start=1 in DONE, go to CALC with cnt=0 and done_flag=0 on the same edge.
REQ-024 SHALL ignore start during CALC: no restart and no change to the sequence.

Reset
REQ-025 SHALL, while reset_a=0, immediately set state=IDLE, cnt=0, product=0, done_flag=0, busy=0 and err=0; sel and shift_cntrl then read 00.
REQ-026 SHALL, on reset asserted mid-CALC, abort the sequence with no partial result retained; after release it SHALL wait in IDLE for start.

Configuration
REQ-027 SHALL, with MULT_ACCUM_ERR_EN defined, set err=1 on any edge where start=1 during CALC; err SHALL stay 1 until reset.
REQ-028 SHALL, without MULT_ACCUM_ERR_EN, keep the err port present and tie it to 0, with no error logic.

Structure
REQ-029 SHALL take the following from a shared package mult_pkg: the state enum, the shift codes SHIFT_0/SHIFT_4/SHIFT_8, and the sel codes.
REQ-030 SHALL instantiate one sub-module, mult_cycle_cnt, containing the 2-bit counter with clear and enable.
REQ-031 SHALL implement the FSM and the accumulator in mult_accum_ctrl.

Verification
REQ-032 The bench SHALL model the upstream chain: a 4x4 product of the nibbles chosen by sel, shifted according to shift_cntrl, driven on shift_out.
REQ-033 Bench scenario: A=0x12, B=0x34, start for one cycle -> done_flag=1 exactly 4 cycles later, product=0x03A8, busy high for 4 cycles.
REQ-034 Bench scenario: A=0xFF, B=0xFF -> product=0xFE01; then A=0x00, B=0xAB with start in DONE -> done_flag drops on the next edge, and 4 cycles later product=0x0000.
REQ-035 Bench scenario: start pulsed at cnt=2 of a run -> result is unchanged and done_flag occurs at the original time; err=1 with MULT_ACCUM_ERR_EN, err=0 without it.
REQ-036 Bench scenario: reset_a pulled low asynchronously at cnt=1 -> all outputs go to reset values without waiting for a clock edge; a new start then gives a correct product.
REQ-037 Bench scenario: check every cycle that sel and shift_cntrl follow the REQ-013 table and that shift_cntrl never equals 11.
